// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-unit types and sizes: request FSM states, halfword geometry, compressed detection.
package instruction_fetch_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int HALFWORD_WIDTH    = 16;
  localparam int FETCH_BUF_HW      = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  function automatic logic is_compressed(input logic [HALFWORD_WIDTH-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realign_buffer.sv
// Three-halfword realignment buffer: head decode is registered-state only; consume is applied before append.
// Latency: an append becomes visible at the head one cycle later; flush empties it in one cycle.
module fetch_realign_buffer
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [31:0]                  flush_pc_i,
  input  logic                         consume_i,
  input  logic                         append_vld_i,
  input  logic                         append_skip_low_i,
  input  logic [31:0]                  append_dat_i,
  output logic                         head_vld_o,
  output logic                         head_is_compressed_o,
  output logic [INSTRUCTION_WIDTH-1:0] head_dat_o,
  output logic [31:0]                  head_pc_o,
  output logic [1:0]                   hw_count_next_o
);

  logic [FETCH_BUF_HW-1:0][HALFWORD_WIDTH-1:0] hw_q, hw_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_rm, cnt_new;
  logic        head_comp;

  assign head_comp            = (cnt_q != 2'd0) && is_compressed(hw_q[0]);
  assign head_vld_o           = head_comp || (cnt_q >= 2'd2);
  assign head_is_compressed_o = head_comp;
  assign head_pc_o            = pc_q;
  assign hw_count_next_o      = cnt_d;

  always_comb begin
    head_dat_o = '0;
    if (head_comp) begin
      head_dat_o = {16'h0000, hw_q[0]};
    end else if (cnt_q != 2'd0) begin
      head_dat_o = {hw_q[1], hw_q[0]};
    end
  end

  always_comb begin
    hw_d    = hw_q;
    pc_d    = pc_q;
    cnt_rm  = {1'b0, cnt_q};
    cnt_new = cnt_rm;
    if (flush_i) begin
      cnt_rm  = 3'd0;
      cnt_new = 3'd0;
      pc_d    = flush_pc_i & ~32'd1;
    end else begin
      if (consume_i) begin
        if (head_comp) begin
          hw_d[0] = hw_q[1];
          hw_d[1] = hw_q[2];
          cnt_rm  = cnt_rm - 3'd1;
          pc_d    = pc_q + 32'd2;
        end else begin
          hw_d[0] = hw_q[2];
          cnt_rm  = cnt_rm - 3'd2;
          pc_d    = pc_q + 32'd4;
        end
      end
      cnt_new = cnt_rm;
      // The request FSM only fetches at <=1 halfword, so the append always fits.
      if (append_vld_i) begin
        for (int i = 0; i < FETCH_BUF_HW; i++) begin
          if (append_skip_low_i) begin
            if (3'(i) == cnt_rm) hw_d[i] = append_dat_i[31:16];
          end else begin
            if (3'(i) == cnt_rm) hw_d[i] = append_dat_i[15:0];
            if (3'(i) == cnt_rm + 3'd1) hw_d[i] = append_dat_i[31:16];
          end
        end
        cnt_new = cnt_rm + (append_skip_low_i ? 3'd1 : 3'd2);
        if (cnt_new > 3'd3) cnt_new = 3'd3;
      end
    end
    cnt_d = cnt_new[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q  <= '0;
      cnt_q <= 2'd0;
      pc_q  <= RESET_PC;
    end else begin
      hw_q  <= hw_d;
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: one outstanding word request, realigned 16/32-bit instructions out over valid/ready.
// Response-to-inst_valid latency is one cycle; decode backpressure stops fetching once 2+ halfwords are buffered.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [31:0]                  imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [31:0]                  imem_rsp_data,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INSTRUCTION_WIDTH-1:0] inst_data,
  output logic [31:0]                  inst_pc,
  output logic                         inst_is_compressed
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         skip_low_q, skip_low_d;
  logic         drop_rsp_q, drop_rsp_d;
  logic         head_vld, consume, rsp_accept;
  logic [1:0]   hw_count_next;

  assign inst_valid     = head_vld & ~redirect_valid;
  assign consume        = inst_valid & inst_ready;
  assign rsp_accept     = (state_q == WAIT) && imem_rsp_valid && !drop_rsp_q && !redirect_valid;
  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = req_addr_q;

  fetch_realign_buffer #(.RESET_PC(RESET_PC)) u_buf (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush_i              (redirect_valid),
    .flush_pc_i           (redirect_pc),
    .consume_i            (consume),
    .append_vld_i         (rsp_accept),
    .append_skip_low_i    (skip_low_q),
    .append_dat_i         (imem_rsp_data),
    .head_vld_o           (head_vld),
    .head_is_compressed_o (inst_is_compressed),
    .head_dat_o           (inst_data),
    .head_pc_o            (inst_pc),
    .hw_count_next_o      (hw_count_next)
  );

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    skip_low_d   = skip_low_q;
    drop_rsp_d   = drop_rsp_q;
    case (state_q)
      IDLE: begin
        if (hw_count_next <= 2'd1) state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
          // A request left over from a redirect must not bump the new target.
          if (!drop_rsp_q) fetch_addr_d = req_addr_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          drop_rsp_d = 1'b0;
          if (rsp_accept) skip_low_d = 1'b0;
          state_d = (hw_count_next <= 2'd1) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      skip_low_d   = redirect_pc[1];
      if (state_q == REQ || (state_q == WAIT && !imem_rsp_valid)) drop_rsp_d = 1'b1;
    end
    if (state_d == REQ && state_q != REQ) req_addr_d = fetch_addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      req_addr_q   <= {RESET_PC[31:2], 2'b00};
      skip_low_q   <= RESET_PC[1];
      drop_rsp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      skip_low_q   <= skip_low_d;
      drop_rsp_q   <= drop_rsp_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: instruction-stream table plus redirect, backpressure and reset sequences.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .inst_data          (inst_data),
    .inst_pc            (inst_pc),
    .inst_is_compressed (inst_is_compressed)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] req_log [$];
  int          mem_delay = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  // Memory model: accepts requests, answers mem_delay cycles after acceptance.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = rd(pend_addr);
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_cnt  = mem_delay;
        req_log.push_back(imem_req_addr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    chk({nm, " req_addr"}, imem_req_addr, RPC);
    chk({nm, " inst_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({nm, " inst_data"}, inst_data, 32'd0);
    chk({nm, " inst_pc"}, inst_pc, RPC);
    chk({nm, " compressed"}, {31'b0, inst_is_compressed}, 32'd0);
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    int i = 0;
    while (!inst_valid && i < 60) begin
      step();
      i++;
    end
    ok = inst_valid;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for inst_valid", nm);
    end
  endtask

  task automatic get_inst(input logic [31:0] ed, input logic [31:0] ep, input logic ec, input string nm);
    bit ok;
    wait_valid(nm, ok);
    if (ok) begin
      chk({nm, " data"}, inst_data, ed);
      chk({nm, " pc"}, inst_pc, ep);
      chk({nm, " compressed"}, {31'b0, inst_is_compressed}, {31'b0, ec});
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
    end
  endtask

  task automatic wait_new_req(input string nm);
    int base = req_log.size();
    int i = 0;
    while (req_log.size() == base && i < 60) begin
      step();
      i++;
    end
    if (req_log.size() == base) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for a request", nm);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        comp;
  } vec_t;

  vec_t vecs [8];
  int   ridx;
  bit   ok;

  initial begin
    vecs[0] = '{32'h00A0_0093, 32'h100, 1'b0};
    vecs[1] = '{32'h0000_0505, 32'h104, 1'b1};
    vecs[2] = '{32'h0000_0001, 32'h106, 1'b1};
    vecs[3] = '{32'h0000_0001, 32'h108, 1'b1};
    vecs[4] = '{32'h00A0_0093, 32'h10A, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h10E, 1'b1};
    vecs[6] = '{32'h1234_4567, 32'h110, 1'b0};
    vecs[7] = '{32'h0000_0013, 32'h114, 1'b0};
    mem[32'h100] = 32'h00A0_0093;
    mem[32'h104] = 32'h0001_0505;
    mem[32'h108] = 32'h0093_0001;
    mem[32'h10C] = 32'h0000_00A0;
    mem[32'h110] = 32'h1234_4567;
    mem[32'h200] = 32'h0001_0001;
    mem[32'h204] = 32'h0000_0513;
    mem[32'h300] = 32'h0000_4501;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    step();
    step();
    chk_reset("reset");

    rst_n = 1'b1;
    step();
    chk("first req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first req_addr", imem_req_addr, RPC);

    for (int v = 0; v < 8; v++) begin
      get_inst(vecs[v].data, vecs[v].pc, vecs[v].comp, $sformatf("vec%0d", v));
    end
    for (int k = 0; k < 5; k++) begin
      if (req_log.size() > k) chk($sformatf("seq req%0d", k), req_log[k], RPC + 32'(4 * k));
      else chk($sformatf("seq req%0d missing", k), 32'(req_log.size()), 32'(k + 1));
    end

    // Redirect to 0x202 while a slow response is outstanding.
    mem_delay  = 3;
    inst_ready = 1'b1;
    wait_new_req("redir wait");
    inst_ready     = 1'b0;
    ridx           = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    #1;
    chk("redir N inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    mem_delay      = 0;
    chk("redir N+1 inst_valid", {31'b0, inst_valid}, 32'd0);
    get_inst(32'h0000_0001, 32'h202, 1'b1, "redir c");
    get_inst(32'h0000_0513, 32'h204, 1'b0, "redir w");
    if (req_log.size() > ridx + 1) begin
      chk("redir req0", req_log[ridx], 32'h200);
      chk("redir req1", req_log[ridx+1], 32'h204);
    end else begin
      chk("redir req count", 32'(req_log.size()), 32'(ridx + 2));
    end

    // Backpressure: head at 0x208 must hold and no request may be issued.
    wait_valid("bp", ok);
    if (ok) begin
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("bp%0d data", c), inst_data, 32'h0000_0013);
        chk($sformatf("bp%0d pc", c), inst_pc, 32'h208);
        chk($sformatf("bp%0d req_valid", c), {31'b0, imem_req_valid}, 32'd0);
        step();
      end
    end

    // Redirect from IDLE: request to the new word in the following cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    chk("idle redir N inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("idle redir N+1 req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("idle redir N+1 req_addr", imem_req_addr, 32'h300);
    chk("idle redir N+1 inst_valid", {31'b0, inst_valid}, 32'd0);
    get_inst(32'h0000_4501, 32'h300, 1'b1, "idle redir c0");
    get_inst(32'h0000_0000, 32'h302, 1'b1, "idle redir c1");

    // Reset while waiting; the stale response lands during reset.
    mem_delay  = 3;
    inst_ready = 1'b1;
    wait_new_req("rst wait");
    inst_ready = 1'b0;
    mem[req_log[req_log.size()-1]] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    chk_reset("mid reset");
    for (int c = 0; c < 6; c++) step();
    chk_reset("after stale rsp");
    mem_delay = 0;
    ridx      = req_log.size();
    rst_n     = 1'b1;
    step();
    chk("post-rst req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post-rst req_addr", imem_req_addr, RPC);
    get_inst(32'h00A0_0093, RPC, 1'b0, "post-rst");
    if (req_log.size() > ridx) chk("post-rst req0", req_log[ridx], RPC);
    else chk("post-rst req count", 32'(req_log.size()), 32'(ridx + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
